// File: rtl/ssd_scan_controller_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment patterns are active-low abcdefg; cathode bytes append an active-low DP bit.
package ssd_scan_controller_pkg;

   typedef enum logic [0:0] {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } state_e;

   localparam logic [7:0] SSD_OFF = 8'hFF;

   localparam logic [6:0] SEG_0 = 7'b0000001;
   localparam logic [6:0] SEG_1 = 7'b1001111;
   localparam logic [6:0] SEG_2 = 7'b0010010;
   localparam logic [6:0] SEG_3 = 7'b0000110;
   localparam logic [6:0] SEG_4 = 7'b1001100;
   localparam logic [6:0] SEG_5 = 7'b0100100;
   localparam logic [6:0] SEG_6 = 7'b0100000;
   localparam logic [6:0] SEG_7 = 7'b0001111;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0000100;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b1100000;
   localparam logic [6:0] SEG_C = 7'b0110001;
   localparam logic [6:0] SEG_D = 7'b1000010;
   localparam logic [6:0] SEG_E = 7'b0110000;
   localparam logic [6:0] SEG_F = 7'b0111000;

endpackage

// File: rtl/ssd_scan_controller_hex_to_ssd.sv
// Combinational hex nibble to active-low abcdefg segment decoder.
module ssd_scan_controller_hex_to_ssd
   import ssd_scan_controller_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] segments
);

   always_comb begin
      segments = SEG_8;
      unique case (nibble)
         4'h0: segments = SEG_0;
         4'h1: segments = SEG_1;
         4'h2: segments = SEG_2;
         4'h3: segments = SEG_3;
         4'h4: segments = SEG_4;
         4'h5: segments = SEG_5;
         4'h6: segments = SEG_6;
         4'h7: segments = SEG_7;
         4'h8: segments = SEG_8;
         4'h9: segments = SEG_9;
         4'hA: segments = SEG_A;
         4'hB: segments = SEG_B;
         4'hC: segments = SEG_C;
         4'hD: segments = SEG_D;
         4'hE: segments = SEG_E;
         4'hF: segments = SEG_F;
      endcase
   end

endmodule

// File: rtl/ssd_scan_controller.sv
// Multiplexed seven-segment scanner with blanking gaps, leading-zero suppression and a
// frame-synchronous double buffer so a scan never mixes old and new digit sets.
module ssd_scan_controller
   import ssd_scan_controller_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 8,
   parameter int unsigned DIGIT_TICKS = 262144,
   parameter int unsigned BLANK_TICKS = 1024,
   parameter int unsigned CNT_W       = 18
) (
   input  logic                    ClkPort,
   input  logic                    Reset,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] load_data,
   input  logic [NUM_DIGITS-1:0]   load_dp,
   input  logic [NUM_DIGITS-1:0]   load_en,
   input  logic                    lz_suppress,
   output logic [NUM_DIGITS-1:0]   anodes,
   output logic [7:0]              cathodes,
   output logic                    frame_done
);

   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIGIT_TICKS - 1);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

   state_e                           state_q;
   logic [CNT_W-1:0]                 cnt_q;
   logic [IDX_W-1:0]                 idx_q;

   logic [NUM_DIGITS-1:0][3:0]       act_data_q;
   logic [NUM_DIGITS-1:0]            act_dp_q;
   logic [NUM_DIGITS-1:0]            act_en_q;
   logic [NUM_DIGITS-1:0][3:0]       pend_data_q;
   logic [NUM_DIGITS-1:0]            pend_dp_q;
   logic [NUM_DIGITS-1:0]            pend_en_q;
   logic                             pend_full_q;

   logic                             wrap;
   logic                             accept;
   logic [NUM_DIGITS-1:0]            supp;
   logic                             zero_above;
   logic                             lit;
   logic [3:0]                       cur_nibble;
   logic [6:0]                       cur_segments;
   logic [NUM_DIGITS-1:0]            anodes_d;
   logic [7:0]                       cathodes_d;

   assign load_ready = !pend_full_q;
   assign accept     = load_valid && load_ready;
   assign wrap       = (state_q == ST_SHOW) && (cnt_q == SHOW_LAST) && (idx_q == LAST_IDX);

   // A digit is suppressed when it and every more significant digit are zero.
   always_comb begin
      supp       = '0;
      zero_above = lz_suppress;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above && (act_data_q[i] == 4'h0);
         supp[i]    = zero_above;
      end
   end

   assign cur_nibble = act_data_q[idx_q];

   ssd_scan_controller_hex_to_ssd u_hex_to_ssd (
      .nibble   (cur_nibble),
      .segments (cur_segments)
   );

   always_comb begin
      lit        = (state_q == ST_SHOW) && act_en_q[idx_q] && !supp[idx_q];
      anodes_d   = '1;
      cathodes_d = SSD_OFF;
      if (lit) begin
         anodes_d[idx_q] = 1'b0;
         cathodes_d      = {cur_segments, ~act_dp_q[idx_q]};
      end
   end

   // Scan FSM and registered display outputs.
   always_ff @(posedge ClkPort) begin
      if (Reset) begin
         state_q    <= ST_BLANK;
         cnt_q      <= '0;
         idx_q      <= '0;
         anodes     <= '1;
         cathodes   <= SSD_OFF;
         frame_done <= 1'b0;
      end else begin
         anodes     <= anodes_d;
         cathodes   <= cathodes_d;
         frame_done <= wrap;
         unique case (state_q)
            ST_BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  state_q <= ST_SHOW;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_SHOW: begin
               if (cnt_q == SHOW_LAST) begin
                  state_q <= ST_BLANK;
                  cnt_q   <= '0;
                  idx_q   <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= ST_BLANK;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // Promotion needs a full pending buffer, acceptance an empty one, so they never collide.
   always_ff @(posedge ClkPort) begin
      if (Reset) begin
         act_data_q  <= '0;
         act_dp_q    <= '0;
         act_en_q    <= '0;
         pend_data_q <= '0;
         pend_dp_q   <= '0;
         pend_en_q   <= '0;
         pend_full_q <= 1'b0;
      end else begin
         if (wrap && pend_full_q) begin
            act_data_q  <= pend_data_q;
            act_dp_q    <= pend_dp_q;
            act_en_q    <= pend_en_q;
            pend_full_q <= 1'b0;
         end
         if (accept) begin
            pend_data_q <= load_data;
            pend_dp_q   <= load_dp;
            pend_en_q   <= load_en;
            pend_full_q <= 1'b1;
         end
      end
   end

endmodule
